delay_scan_ctrl_mc: RTL
=======================

// Module: delay_scan_ctrl_mc
// PURPOSE
//  Multi-channel IDELAY auto-alignment sequencer for the LVDS input blocks. Scans N_CH P/N delay pairs
//  one channel at a time with a single scan FSM, finds the widest error-free window and centres P in it.
//  Sits between the per-channel deserialisers and the per-channel IDELAY set controllers.
//  Generalises the single-channel controller in channel count, data width, tap width and scan step.
// PARAMETERS
//  N_CH       4    number of channels
//  DATA_W     8    deserialised bits per channel per clk160
//  DLY_W      9    IDELAY tap-value width
//  STEP       8    coarse scan step in taps (power of two, < 2**DLY_W)
//  N_OFFSET   8    N-path offset in taps above P during the scan
//  TRANS_CNT  16   transition-carrying words counted per scan point
//  TIMEOUT    4096 clk160 cycles without a transition before a channel is abandoned
// PORTS
//  clk160                    in  1              system clock
//  totalCounterResetb_manual in  1              reset, asynchronous, active-low
//  start                     in  1              rising edge starts a full align pass
//  d_out_p / d_out_n         in  N_CH*DATA_W    deserialised P and N-path data
//  delay_ready_p / _n        in  N_CH           per-channel set controller has reached its target
//  delay_target_p / _n       out N_CH*DLY_W     requested tap values
//  busy / done               out 1              pass in progress / one-cycle pulse at end of pass
//  align_ok                  out N_CH           channel found a non-empty window
//  eye_width                 out N_CH*(DLY_W)   widest window, in taps
//  waiting_for_transitions   out 1              active channel currently sees no data transitions
//  bit_align_errors          out N_CH*16        monitor error counters (see CONFIGURATION)
//  reset_counters            in  1              synchronous clear of bit_align_errors
// BEHAVIOUR
//  - Reset values: all targets 0, busy 0, done 0, align_ok 0, eye_width 0, waiting_for_transitions 1, FSM IDLE.
//  - Bit error per word: err = |(~(d_out_p[ch] ^ d_out_n[ch])). Transition: any bit differs from its
//    neighbour, including previous word's bit 0 against bit DATA_W-1.
//  - FSM: IDLE -start edge-> SEL(ch=0) -> SET -> WAITRDY -> CLR -> WAITCNT -> CHECK -> (SET | CENTER)
//    -> WAITCTR -> NEXT -> (SEL ch+1 | DONE) -> IDLE. start while busy is ignored.
//  - SET: P=scan_pos, N=min(scan_pos+N_OFFSET, 2**DLY_W-1). scan_pos starts at 2**DLY_W-STEP, descends by STEP.
//  - WAITRDY: wait until delay_ready_p[ch] && delay_ready_n[ch].
//  - CLR: clear window error flag and transition counter, reload timeout counter.
//  - WAITCNT: count transition words to TRANS_CNT; err in any counted word sets the error flag.
//    waiting_for_transitions = !transition, registered, forced 0 on exit. Timeout -> align_ok[ch]=0,
//    eye_width[ch]=0, P=N=2**(DLY_W-1), go NEXT.
//  - CHECK: clean point -> run+=1 else run=0. If run >= max_run: max_run=run, max_loc=scan_pos (ties: lower
//    delay wins). If scan_pos==0 -> CENTER (no wrap), else scan_pos-=STEP, go SET.
//  - CENTER: max_run==0 -> align_ok=0, P=N=2**(DLY_W-1). Else P=N=max_loc+(max_run*STEP)/2, saturating
//    at 2**DLY_W-1; eye_width=max_run*STEP; align_ok=1. WAITCTR waits for ready as in WAITRDY.
//  - done pulses one cycle in DONE; busy high from SEL to DONE inclusive. Channels other than ch keep targets.
//  - Reset mid-pass: immediate return to reset values; no partial results kept.
// CONFIGURATION
//  DELAY_CTRL_ERRCNT_EN defined: per-channel 16-bit saturating bit_align_errors count err words while
//   busy==0 and align_ok[ch]==1; cleared by reset or reset_counters (reset_counters wins over increment).
//  Not defined: bit_align_errors tied to 0, counters not built; reset_counters ignored.
// STRUCTURE
//  Package delay_ctrl_pkg: FSM state enum, STEP/TRANS_CNT/TIMEOUT defaults, mid-scale and saturate helpers.
//  Sub-module dly_ch_mon (one per channel): err/transition detection and optional error counter.
//  Scan FSM, run-length tracker and channel mux stay in this module.
// TESTING
//  1 Ch0 clean for P in [64,127], errors elsewhere (N_CH=1,STEP=8) -> eye_width=64, P=N=96, align_ok=1, done 1 cycle.
//  2 Channel with errors at every point -> align_ok=0, P=N=256, eye_width=0; other channels aligned normally.
//  3 Constant data (no transitions) on ch2 -> waiting_for_transitions=1, timeout after 4096 cycles, align_ok[2]=0.
//  4 Two equal 32-tap windows at 300-331 and 40-71 -> lower window chosen, P=56.
//  5 Reset asserted in WAITCNT of ch1 -> all outputs return to reset values next edge; new start completes pass.
//  6 ERRCNT_EN: 70000 err words after alignment -> count saturates at 65535; reset_counters -> 0 next cycle.

Source files
------------

// File: rtl/delay_ctrl_pkg.sv
// Shared types and helpers for the IDELAY scan sequencer.
// Holds the scan FSM encoding, default scan constants and tap arithmetic helpers.
package delay_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SEL,
    S_SET,
    S_WAITRDY,
    S_CLR,
    S_WAITCNT,
    S_CHECK,
    S_CENTER,
    S_WAITCTR,
    S_NEXT,
    S_DONE
  } scan_state_e;

  localparam int unsigned STEP_DEF      = 8;
  localparam int unsigned TRANS_CNT_DEF = 16;
  localparam int unsigned TIMEOUT_DEF   = 4096;
  localparam int unsigned ERRCNT_W      = 16;

  function automatic int unsigned mid_scale(input int unsigned w);
    return 32'd1 << (w - 32'd1);
  endfunction

  function automatic int unsigned sat_max(
    input int unsigned v,
    input int unsigned w
  );
    int unsigned m;
    m = (32'd1 << w) - 32'd1;
    return (v > m) ? m : v;
  endfunction

endpackage

// File: rtl/delay_scan_ctrl_mc_mon.sv
// Per-channel P/N word monitor: bit-error and transition detection.
// Builds the saturating error counter only when DELAY_CTRL_ERRCNT_EN is defined.
module dly_ch_mon
  import delay_ctrl_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                clk160,
  input  logic                totalCounterResetb_manual,
  input  logic [DATA_W-1:0]   d_p,
  input  logic [DATA_W-1:0]   d_n,
  input  logic                cnt_en,
  input  logic                cnt_clr,
  output logic                err,
  output logic                trans,
  output logic [ERRCNT_W-1:0] err_cnt
);

  logic prev_b0_q;

  // N carries the complement of P when sampled cleanly
  assign err = |(~(d_p ^ d_n));

  assign trans = (|(d_p[DATA_W-1:1] ^ d_p[DATA_W-2:0]))
               | (prev_b0_q ^ d_p[DATA_W-1]);

  always_ff @(posedge clk160 or negedge totalCounterResetb_manual) begin
    if (!totalCounterResetb_manual) begin
      prev_b0_q <= 1'b0;
    end else begin
      prev_b0_q <= d_p[0];
    end
  end

`ifdef DELAY_CTRL_ERRCNT_EN
  logic [ERRCNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (cnt_en && err && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk160 or negedge totalCounterResetb_manual) begin
    if (!totalCounterResetb_manual) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign err_cnt = cnt_q;
`else
  logic unused_cnt;
  assign unused_cnt = cnt_en ^ cnt_clr;
  assign err_cnt    = '0;
`endif

endmodule

// File: rtl/delay_scan_ctrl_mc.sv
// Multi-channel IDELAY auto-alignment: scans P/N taps per channel, centres P in the widest clean window.
// Define DELAY_CTRL_ERRCNT_EN to build the post-alignment bit_align_errors counters.
module delay_scan_ctrl_mc
  import delay_ctrl_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int DATA_W    = 8,
  parameter int DLY_W     = 9,
  parameter int STEP      = STEP_DEF,
  parameter int N_OFFSET  = 8,
  parameter int TRANS_CNT = TRANS_CNT_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                       clk160,
  input  logic                       totalCounterResetb_manual,
  input  logic                       start,
  input  logic [N_CH*DATA_W-1:0]     d_out_p,
  input  logic [N_CH*DATA_W-1:0]     d_out_n,
  input  logic [N_CH-1:0]            delay_ready_p,
  input  logic [N_CH-1:0]            delay_ready_n,
  output logic [N_CH*DLY_W-1:0]      delay_target_p,
  output logic [N_CH*DLY_W-1:0]      delay_target_n,
  output logic                       busy,
  output logic                       done,
  output logic [N_CH-1:0]            align_ok,
  output logic [N_CH*DLY_W-1:0]      eye_width,
  output logic                       waiting_for_transitions,
  output logic [N_CH*ERRCNT_W-1:0]   bit_align_errors,
  input  logic                       reset_counters
);

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int RUN_W = DLY_W + 1;
  localparam int CNT_W = $clog2(TRANS_CNT + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [DLY_W-1:0] MID_V    = DLY_W'(mid_scale(DLY_W));
  localparam logic [DLY_W-1:0] SCAN_TOP = DLY_W'((1 << DLY_W) - STEP);
  localparam logic [DLY_W-1:0] STEP_V   = DLY_W'(STEP);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TRANS_CNT - 1);
  localparam logic [TMO_W-1:0] TMO_V    = TMO_W'(TIMEOUT);

  scan_state_e state_q, state_d;

  logic [CH_W-1:0]  ch_q, ch_d;
  logic [DLY_W-1:0] scan_pos_q, scan_pos_d;
  logic [DLY_W-1:0] max_loc_q, max_loc_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [RUN_W-1:0] max_run_q, max_run_d;
  logic [RUN_W-1:0] run_n;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_flag_q, err_flag_d;
  logic             wft_q, wft_d;
  logic             start_q;

  logic [N_CH-1:0][DLY_W-1:0] tgt_p_q, tgt_p_d;
  logic [N_CH-1:0][DLY_W-1:0] tgt_n_q, tgt_n_d;
  logic [N_CH-1:0][DLY_W-1:0] eye_q, eye_d;
  logic [N_CH-1:0]            ok_q, ok_d;

  logic [N_CH-1:0] err_v, trans_v;
  logic            err_a, trans_a, rdy_a, start_rise;
  int unsigned     width_i, centre_i;

  for (genvar i = 0; i < N_CH; i++) begin : g_mon
    dly_ch_mon #(
      .DATA_W(DATA_W)
    ) u_mon (
      .clk160                    (clk160),
      .totalCounterResetb_manual (totalCounterResetb_manual),
      .d_p                       (d_out_p[i*DATA_W +: DATA_W]),
      .d_n                       (d_out_n[i*DATA_W +: DATA_W]),
      .cnt_en                    (!busy && ok_q[i]),
      .cnt_clr                   (reset_counters),
      .err                       (err_v[i]),
      .trans                     (trans_v[i]),
      .err_cnt                   (bit_align_errors[i*ERRCNT_W +: ERRCNT_W])
    );
  end

  assign err_a      = err_v[ch_q];
  assign trans_a    = trans_v[ch_q];
  assign rdy_a      = delay_ready_p[ch_q] && delay_ready_n[ch_q];
  assign start_rise = start && !start_q;

  assign width_i  = 32'(max_run_q) * 32'(STEP);
  assign centre_i = 32'(max_loc_q) + (width_i >> 1);

  always_ff @(posedge clk160 or negedge totalCounterResetb_manual) begin
    if (!totalCounterResetb_manual) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      scan_pos_q <= '0;
      max_loc_q  <= '0;
      run_q      <= '0;
      max_run_q  <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      err_flag_q <= 1'b0;
      wft_q      <= 1'b1;
      start_q    <= 1'b0;
      tgt_p_q    <= '0;
      tgt_n_q    <= '0;
      eye_q      <= '0;
      ok_q       <= '0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      scan_pos_q <= scan_pos_d;
      max_loc_q  <= max_loc_d;
      run_q      <= run_d;
      max_run_q  <= max_run_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      err_flag_q <= err_flag_d;
      wft_q      <= wft_d;
      start_q    <= start;
      tgt_p_q    <= tgt_p_d;
      tgt_n_q    <= tgt_n_d;
      eye_q      <= eye_d;
      ok_q       <= ok_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    scan_pos_d = scan_pos_q;
    max_loc_d  = max_loc_q;
    run_d      = run_q;
    max_run_d  = max_run_q;
    run_n      = '0;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    err_flag_d = err_flag_q;
    wft_d      = wft_q;
    tgt_p_d    = tgt_p_q;
    tgt_n_d    = tgt_n_q;
    eye_d      = eye_q;
    ok_d       = ok_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          ch_d    = '0;
          state_d = S_SEL;
        end
      end
      S_SEL: begin
        scan_pos_d = SCAN_TOP;
        run_d      = '0;
        max_run_d  = '0;
        max_loc_d  = '0;
        state_d    = S_SET;
      end
      S_SET: begin
        tgt_p_d[ch_q] = scan_pos_q;
        tgt_n_d[ch_q] = DLY_W'(sat_max(32'(scan_pos_q) + 32'(N_OFFSET), DLY_W));
        state_d       = S_WAITRDY;
      end
      S_WAITRDY: begin
        if (rdy_a) state_d = S_CLR;
      end
      S_CLR: begin
        err_flag_d = 1'b0;
        cnt_d      = '0;
        tmo_d      = TMO_V;
        state_d    = S_WAITCNT;
      end
      S_WAITCNT: begin
        wft_d = !trans_a;
        if (trans_a) begin
          tmo_d = TMO_V;
          if (err_a) err_flag_d = 1'b1;
          if (cnt_q == CNT_LAST) begin
            wft_d   = 1'b0;
            state_d = S_CHECK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (tmo_q == TMO_W'(1)) begin
          // dead link: park mid-scale and give up on this channel
          wft_d         = 1'b0;
          ok_d[ch_q]    = 1'b0;
          eye_d[ch_q]   = '0;
          tgt_p_d[ch_q] = MID_V;
          tgt_n_d[ch_q] = MID_V;
          state_d       = S_NEXT;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      S_CHECK: begin
        run_n = err_flag_q ? '0 : run_q + 1'b1;
        run_d = run_n;
        // descending scan, so >= lets the lower-delay window win ties
        if (run_n >= max_run_q) begin
          max_run_d = run_n;
          max_loc_d = scan_pos_q;
        end
        if (scan_pos_q == '0) begin
          state_d = S_CENTER;
        end else begin
          scan_pos_d = scan_pos_q - STEP_V;
          state_d    = S_SET;
        end
      end
      S_CENTER: begin
        if (max_run_q == '0) begin
          ok_d[ch_q]    = 1'b0;
          eye_d[ch_q]   = '0;
          tgt_p_d[ch_q] = MID_V;
          tgt_n_d[ch_q] = MID_V;
        end else begin
          ok_d[ch_q]    = 1'b1;
          eye_d[ch_q]   = DLY_W'(sat_max(width_i, DLY_W));
          tgt_p_d[ch_q] = DLY_W'(sat_max(centre_i, DLY_W));
          tgt_n_d[ch_q] = DLY_W'(sat_max(centre_i, DLY_W));
        end
        state_d = S_WAITCTR;
      end
      S_WAITCTR: begin
        if (rdy_a) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (ch_q == CH_W'(N_CH - 1)) begin
          state_d = S_DONE;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = S_SEL;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy                    = (state_q != S_IDLE);
  assign done                    = (state_q == S_DONE);
  assign delay_target_p          = tgt_p_q;
  assign delay_target_n          = tgt_n_q;
  assign eye_width               = eye_q;
  assign align_ok                = ok_q;
  assign waiting_for_transitions = wft_q;

endmodule
